// File: rtl/fabric_cfg_pkg.sv
// Shared helpers for programmable fabric blocks: clog2, config field widths
// and total scan-chain length.
package fabric_cfg_pkg;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Select field width; at least one bit even for a single input.
  function automatic int unsigned sel_width(input int unsigned w_in);
    int unsigned s;
    s = clog2(w_in);
    return (s < 1) ? 1 : s;
  endfunction

  // Per-output config field: select bits plus one enable bit.
  function automatic int unsigned fld_width(input int unsigned w_in);
    return sel_width(w_in) + 1;
  endfunction

  // Total config chain length for a block with w_out configurable outputs.
  function automatic int unsigned cfg_bits(input int unsigned w_in,
                                           input int unsigned w_out);
    return w_out * fld_width(w_in);
  endfunction

endpackage

// File: rtl/cfg_shift_chain.sv
// Serial configuration chain with shadow/active double buffering.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   cfg_en       - shift enable
//   cfg_in       - serial bit in (enters at the MSB)
//   cfg_commit   - copy shadow to active if a full word has been shifted
//   cfg_out      - serial bit out (shadow LSB)
//   cfg_loaded   - at least CFG_BITS shifts since last accepted commit/reset
//   cfg_err      - one-cycle pulse after a rejected commit
//   active       - committed configuration vector
module cfg_shift_chain
  import fabric_cfg_pkg::*;
#(
  parameter int unsigned CFG_BITS = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_en,
  input  logic                cfg_in,
  input  logic                cfg_commit,
  output logic                cfg_out,
  output logic                cfg_loaded,
  output logic                cfg_err,
  output logic [CFG_BITS-1:0] active
);

  localparam int unsigned CNT_W = clog2(CFG_BITS + 1);

  logic [CFG_BITS-1:0] r_shadow;
  logic [CFG_BITS-1:0] r_active;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_loaded;
  logic                r_err;

  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_commit_ok;

  assign w_commit_ok = cfg_commit & r_loaded;

  // Counter: restarts on accepted commit (counting a concurrent shift),
  // otherwise saturating increment per shift.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_commit_ok) begin
      w_cnt_next = cfg_en ? CNT_W'(1) : CNT_W'(0);
    end else if (cfg_en && (r_cnt != CNT_W'(CFG_BITS))) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  // Shadow shift, counter, loaded flag, error pulse and active register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
      r_cnt    <= '0;
      r_loaded <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (cfg_en) begin
        r_shadow <= {cfg_in, r_shadow[CFG_BITS-1:1]};
      end
      if (w_commit_ok) begin
        r_active <= r_shadow;
      end
      r_cnt    <= w_cnt_next;
      r_loaded <= (w_cnt_next == CNT_W'(CFG_BITS));
      r_err    <= cfg_commit & ~r_loaded;
    end
  end

  assign cfg_out    = r_shadow[0];
  assign cfg_loaded = r_loaded;
  assign cfg_err    = r_err;
  assign active     = r_active;

endmodule

// File: rtl/switch_box_mux_stage.sv
// Switch-box output stage: each of W_OUT outputs selects one of W_IN input
// tracks under a scan-loaded, commit-protected configuration.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   data_in     - input tracks from the connector
//   data_out    - routed output tracks (registered when REG_OUT=1)
//   cfg_en, cfg_in, cfg_out        - config scan chain
//   cfg_commit, cfg_loaded, cfg_err - commit handshake
module switch_box_mux_stage
  import fabric_cfg_pkg::*;
#(
  parameter int unsigned W_IN    = 7,
  parameter int unsigned W_OUT   = 5,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W_IN-1:0]  data_in,
  output logic [W_OUT-1:0] data_out,
  input  logic             cfg_en,
  input  logic             cfg_in,
  output logic             cfg_out,
  input  logic             cfg_commit,
  output logic             cfg_loaded,
  output logic             cfg_err
);

  localparam int unsigned SEL_W    = sel_width(W_IN);
  localparam int unsigned FLD_W    = fld_width(W_IN);
  localparam int unsigned CFG_BITS = cfg_bits(W_IN, W_OUT);
  localparam int unsigned PAD_W    = 1 << SEL_W;

  logic [CFG_BITS-1:0] w_active;
  logic [PAD_W-1:0]    w_pad;
  logic [W_OUT-1:0]    w_route;

  cfg_shift_chain #(
    .CFG_BITS (CFG_BITS)
  ) u_cfg (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_en     (cfg_en),
    .cfg_in     (cfg_in),
    .cfg_commit (cfg_commit),
    .cfg_out    (cfg_out),
    .cfg_loaded (cfg_loaded),
    .cfg_err    (cfg_err),
    .active     (w_active)
  );

  // Zero-pad so every select code indexes a defined bit.
  assign w_pad = PAD_W'(data_in);

  // Per-output mux with enable and out-of-range guard.
  always_comb begin
    w_route = '0;
    for (int j = 0; j < int'(W_OUT); j++) begin
      logic [SEL_W-1:0] sel;
      logic             en;
      sel = w_active[j*FLD_W +: SEL_W];
      en  = w_active[j*FLD_W + SEL_W];
      if (en && (32'(sel) < 32'(W_IN))) begin
        w_route[j] = w_pad[sel];
      end
    end
  end

  generate
    if (REG_OUT) begin : g_reg_out
      logic [W_OUT-1:0] r_data_out;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data_out <= '0;
        end else begin
          r_data_out <= w_route;
        end
      end
      assign data_out = r_data_out;
    end else begin : g_comb_out
      assign data_out = w_route;
    end
  endgenerate

endmodule

// File: tb/tb_switch_box_mux_stage.sv
// Directed self-checking bench for switch_box_mux_stage at default parameters.
module tb_switch_box_mux_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] data_in;
  logic [4:0] data_out;
  logic       cfg_en;
  logic       cfg_in;
  logic       cfg_out;
  logic       cfg_commit;
  logic       cfg_loaded;
  logic       cfg_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  switch_box_mux_stage #(
    .W_IN    (7),
    .W_OUT   (5),
    .REG_OUT (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_out   (data_out),
    .cfg_en     (cfg_en),
    .cfg_in     (cfg_in),
    .cfg_out    (cfg_out),
    .cfg_commit (cfg_commit),
    .cfg_loaded (cfg_loaded),
    .cfg_err    (cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [19:0] word, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      cfg_en = 1'b1;
      cfg_in = word[i];
      tick();
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    data_in    = 7'h7F;
    cfg_en     = 1'b0;
    cfg_in     = 1'b0;
    cfg_commit = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_cfg_out", 32'(cfg_out), 32'h0);
    check("rst_loaded", 32'(cfg_loaded), 32'h0);
    check("rst_err", 32'(cfg_err), 32'h0);
    #2 rst_n = 1'b1;
    tick();

    // out0 = in6 enabled
    shift_bits(20'h0000E, 0, 19);
    check("loaded_after19", 32'(cfg_loaded), 32'h0);
    shift_bits(20'h0000E, 19, 1);
    check("loaded_after20", 32'(cfg_loaded), 32'h1);
    check("still_disabled", 32'(data_out), 32'h0);
    commit();
    check("loaded_clr_commit", 32'(cfg_loaded), 32'h0);
    check("no_err_commit", 32'(cfg_err), 32'h0);
    data_in = 7'b1000000;
    tick();
    check("route_in6_hi", 32'(data_out), 32'h01);
    data_in = 7'b0111111;
    tick();
    check("route_in6_lo", 32'(data_out), 32'h00);

    // Early commit rejected, then accepted
    data_in = 7'b1000000;
    tick();
    shift_bits(20'h0000F, 0, 19);
    commit();
    check("early_err_pulse", 32'(cfg_err), 32'h1);
    check("early_loaded", 32'(cfg_loaded), 32'h0);
    tick();
    check("early_err_clear", 32'(cfg_err), 32'h0);
    check("early_active_kept", 32'(data_out), 32'h01);
    shift_bits(20'h0000F, 19, 1);
    check("late_loaded", 32'(cfg_loaded), 32'h1);
    commit();
    check("late_no_err", 32'(cfg_err), 32'h0);

    // Out-of-range select 7
    data_in = 7'h7F;
    tick();
    check("oor_guard", 32'(data_out), 32'h00);

    // Chain pass-through and simultaneous shift+commit
    shift_bits(20'hA5A5A, 0, 20);
    check("chain_out0", 32'(cfg_out), 32'h0);
    shift_bits(20'h00000, 0, 1);
    check("chain_out1", 32'(cfg_out), 32'h1);
    shift_bits(20'h00000, 0, 1);
    check("chain_out2", 32'(cfg_out), 32'h0);
    shift_bits(20'h00000, 0, 1);
    check("chain_out3", 32'(cfg_out), 32'h1);
    check("sat_loaded", 32'(cfg_loaded), 32'h1);
    // shadow is now 20'h14B4B: out0,out2 enabled with select 3
    cfg_en     = 1'b1;
    cfg_in     = 1'b1;
    cfg_commit = 1'b1;
    tick();
    cfg_en     = 1'b0;
    cfg_in     = 1'b0;
    cfg_commit = 1'b0;
    check("simul_loaded", 32'(cfg_loaded), 32'h0);
    check("simul_no_err", 32'(cfg_err), 32'h0);
    data_in = 7'b0001000;
    tick();
    check("simul_route_hi", 32'(data_out), 32'h05);
    data_in = 7'h77;
    tick();
    check("simul_route_lo", 32'(data_out), 32'h00);

    // Counter is 1; 19 more shifts would load, so only 10 here then reset
    data_in = 7'b0001000;
    shift_bits(20'hFFFFF, 0, 10);
    check("pre_rst_cfg_out", 32'(cfg_out), 32'h1);
    check("pre_rst_data_out", 32'(data_out), 32'h05);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cfg_out", 32'(cfg_out), 32'h0);
    check("mid_rst_data_out", 32'(data_out), 32'h00);
    check("mid_rst_loaded", 32'(cfg_loaded), 32'h0);
    #1 rst_n = 1'b1;
    tick();
    shift_bits(20'hFFFFF, 0, 19);
    check("post_rst_loaded", 32'(cfg_loaded), 32'h0);
    commit();
    check("post_rst_err", 32'(cfg_err), 32'h1);
    tick();
    check("post_rst_err_clr", 32'(cfg_err), 32'h0);
    check("post_rst_disabled", 32'(data_out), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
